skid_buf32: RTL
===============

# skid_buf32

Two-entry elastic pipeline buffer carrying 32-bit words with a valid/ready handshake on both sides. It sits directly upstream of the 32-bit pipeline register stage and feeds it. It decouples backpressure so that `in_ready` is driven from a flop, with no combinational path from `out_ready`. It sustains one transfer per cycle and counts downstream stall cycles for debug.

## Interface
- `WIDTH`, 32, data word width.
- `CNT_W`, 16, width of the stall counter.

- `clk`  in  1  rising-edge clock, single clock domain.
- `res`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  upstream word.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  buffer can accept; equals (state != FULL), registered.
- `out_data`  out  WIDTH  head word (main register).
- `out_valid`  out  1  head word valid; equals (state != EMPTY).
- `out_ready`  in  1  downstream accepts head word.
- `flush`  in  1  synchronous discard of all contents.
- `count`  out  2  occupancy, 0..2.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `out_valid & ~out_ready`.

## Operation
- Storage: `main` register (drives `out_data`) and `skid` register. State is EMPTY/BUSY/FULL, encoded as `count` = 0/1/2.
- push = `in_valid & in_ready`; pop = `out_valid & out_ready`.
- EMPTY:
  - push: `main` <= `in_data`; go to BUSY.
  - Otherwise: hold.
- BUSY:
  - push & pop: `main` <= `in_data`; stay BUSY.
  - push only: `skid` <= `in_data`; go to FULL.
  - pop only: go to EMPTY.
  - Neither: hold.
- FULL (`in_ready`=0, so no push):
  - pop: `main` <= `skid`; go to BUSY.
  - Otherwise: hold.
- Ordering is strictly FIFO. No word is duplicated or lost except by `flush` or `res`.
- `flush`=1 has the highest priority:
  - Next state is EMPTY.
  - A push in the same cycle is discarded.
  - A pop in the same cycle counts as delivered.
  - Data registers are not cleared.
  - `stall_cnt` is unaffected.
- `stall_cnt`:
  - Increments at each edge where `out_valid & ~out_ready`.
  - Saturates at all-ones.
  - Cleared only by `res`.
- Data registers load only on push or on the skid-to-main transfer. They hold otherwise, which minimises toggling.

## Timing
- Reset values, applied asynchronously on `res`=1 and held until release:
  - state EMPTY, `count`=0, `out_valid`=0, `in_ready`=1.
  - `out_data`=0, `skid`=0, `stall_cnt`=0.
- First push is possible at the first rising edge after `res` falls.
- Latency: a word pushed at edge N appears on `out_data`, with `out_valid`=1, after edge N (one cycle) when the buffer was EMPTY. It is pushed behind queued words otherwise.
- Throughput: with `out_ready` held 1, one word per cycle indefinitely. The buffer never reaches FULL in this case.
- `in_ready` and `out_valid` change only after a clock edge or asynchronous reset. Neither depends combinationally on any input.
- `out_ready` dropping while BUSY and `in_valid`=1: the buffer goes FULL at the next edge, and `in_ready`=0 from that edge on.
- Reset mid-operation: contents are lost immediately, with no partial transfer completed.
- Upstream must hold `in_data` stable while `in_valid & ~in_ready`. The downstream sees `out_data` stable while `out_valid & ~out_ready`.

## Test plan
- Reset, then release:
  - During reset: `out_valid`=0, `in_ready`=1, `count`=0, `out_data`=0, `stall_cnt`=0.
  - After release: push 32'd100; next cycle `out_data`=100, `out_valid`=1.
- Streaming with `out_ready`=1, pushing 1..8 on consecutive cycles:
  - Outputs 1..8 on consecutive cycles, each one cycle after its push.
  - `count` never exceeds 1; `in_ready` stays 1.
- Backpressure with `out_ready`=0, pushing 200, 300, 400:
  - 200 and 300 are accepted; `count`=2; `in_ready`=0; 400 is held.
  - Raise `out_ready`: outputs 200, 300, 400 in order with none lost.
  - `stall_cnt` equals the number of stalled valid cycles.
- `flush` while FULL with `in_valid`=1:
  - Next cycle `count`=0, `out_valid`=0.
  - The coincident word is not delivered.
  - Subsequent push 32'hDEADBEEF is output normally.
- Asynchronous `res` pulse between clock edges while FULL:
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - Operation resumes after release.
- Force `out_valid` stalled for 70000 cycles:
  - `stall_cnt` saturates at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/skid_buf32.sv
// Two-entry elastic buffer (main + skid) with valid/ready on both sides; in_ready and out_valid come straight from flops.
// Zero-bubble streaming at one word per cycle, plus a saturating downstream-stall counter for debug.
module skid_buf32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       count,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             push;
  logic             pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    case (state_q)
      EMPTY: begin
        if (push) begin
          main_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush drops everything queued but leaves the data registers untouched.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_q     <= stall_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = state_q;
  assign stall_cnt = stall_q;

endmodule
